alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute stage directly downstream of the 8x16 register file. Consumes SR1_OUT/SR2_OUT
//  (or sign-extended imm5) and produces the ALU result that drives the datapath bus.
//  Implements LC-3 ADD/AND/NOT/PASSA combinationally, plus an iterative 16-cycle MUL
//  extension with a Start/Busy/Done handshake. Also holds the NZP condition-code
//  register, which loads from the bus.
// PARAMETERS
//  WIDTH  16  data width; MUL iteration count equals WIDTH
// PORTS
//  Clk      in   1      system clock, rising edge
//  Reset_n  in   1      asynchronous, active-low reset
//  SR1_OUT  in   WIDTH  operand A from register file
//  SR2_OUT  in   WIDTH  operand B from register file
//  IMM5     in   5      IR[4:0] immediate
//  SR2MUX   in   1      1: B = sext(IMM5); 0: B = SR2_OUT
//  ALUK     in   3      000 ADD, 001 AND, 010 NOT A, 011 PASSA, 100 MUL, 101-111 reserved
//  Start    in   1      one-cycle request to begin a MUL (honoured only when ALUK=100)
//  LD_CC    in   1      load NZP from Bus on this edge
//  Bus      in   WIDTH  datapath bus value (source for NZP)
//  ALU_OUT  out  WIDTH  result
//  Busy     out  1      MUL in progress
//  Done     out  1      one-cycle pulse: MUL result valid
//  N, Z, P  out  1      condition codes
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE; Busy=0; Done=0; product/result reg=0; N,Z,P=0,1,0.
//  Operand B = SR2MUX ? {{(WIDTH-5){IMM5[4]}},IMM5} : SR2_OUT.
//  ALUK 000-011: ALU_OUT = A+B (mod 2^WIDTH) / A&B / ~A / A; purely combinational, 0-cycle.
//  ALUK 101-111: ALU_OUT = 0.
//  ALUK 100: ALU_OUT = result register (low WIDTH bits of last completed product).
//  FSM states IDLE, MUL, FIN:
//   IDLE: Start=1 && ALUK=100 at edge e0 -> latch A and B, clear accumulator, go MUL;
//         Busy=1 from e0. Start with any other ALUK is ignored.
//   MUL:  one shift-add step per edge (if B[0], acc += A; A<<=1; B>>=1).
//         Step counter wraps after WIDTH steps (edges e1..eW) -> FIN.
//   FIN:  entered at eW. Result register <= acc; Busy=0; Done=1 for exactly one cycle.
//         Next edge -> IDLE, Done=0.
//   Start asserted while Busy=1 is ignored; operands latched at e0 are unaffected by later
//   SR1_OUT/SR2_OUT changes.
//   A Start in FIN is ignored; a new MUL may start from IDLE on the following edge.
//  MUL latency: Start edge to Done high = WIDTH edges (16); result is the low WIDTH bits
//   and overflow is discarded. Signed operands give the correct low half (two's complement).
//  Reset_n low mid-MUL: abort immediately -> IDLE; Busy=0; Done=0; result=0.
//  CC: on an edge with LD_CC=1: N=Bus[MSB]; Z=(Bus==0); P=!N&&!Z. Exactly one bit is set.
//   Otherwise the CC bits hold.
//  LD_CC is independent of the FSM; a simultaneous LD_CC and MUL step both take effect.
// TESTING
//  1 Reset: Reset_n=0 with Clk running -> Busy=0, Done=0, NZP=010; ALUK=100 -> ALU_OUT=0.
//  2 Combinational ops: A=16'h7FFF, B=16'h0001, SR2MUX=0.
//    ADD -> 8000; AND -> 0001; NOT -> 8000; PASSA -> 7FFF.
//    SR2MUX=1, IMM5=5'h1F, ADD -> 7FFE.
//  3 MUL: A=16'd300, B=16'd7, Start pulse -> Busy high 16 cycles, Done pulse on 16th edge,
//    ALU_OUT=16'd2100. Repeat with A=FFFD (-3), B=0005 -> FFF1. A=1234, B=0000 -> 0000.
//  4 Handshake: Start re-pulsed at cycle 5 of a MUL and operand inputs changed mid-op
//    -> no restart, result from original operands, single Done.
//    Back-to-back Start in cycle after Done -> second MUL completes correctly.
//  5 Reset mid-op: Reset_n low at cycle 8 of MUL -> Busy, Done drop asynchronously,
//    result=0, no Done after release.
//  6 CC: LD_CC with Bus=8000 -> 100; 0000 -> 010; 0001 -> 001; LD_CC=0 with Bus changing
//    -> NZP held.

Source files
------------

// File: rtl/alu_exec.sv
// LC-3 execute stage: combinational ADD/AND/NOT/PASSA, an iterative shift-add MUL with a
// Start/Busy/Done handshake, and the NZP condition-code register loaded from the bus.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] SR1_OUT,
    input  logic [WIDTH-1:0] SR2_OUT,
    input  logic [4:0]       IMM5,
    input  logic             SR2MUX,
    input  logic [2:0]       ALUK,
    input  logic             Start,
    input  logic             LD_CC,
    input  logic [WIDTH-1:0] Bus,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Busy,
    output logic             Done,
    output logic             N,
    output logic             Z,
    output logic             P
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN
    } state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] op_a;
    logic signed [WIDTH-1:0] op_b;
    logic signed [WIDTH-1:0] alu_res;
    logic        [WIDTH-1:0] mcand;
    logic        [WIDTH-1:0] mplier;
    logic        [WIDTH-1:0] acc;
    logic        [WIDTH-1:0] acc_step;
    logic        [WIDTH-1:0] result_q;
    logic        [CW-1:0]    step_cnt;
    logic                    start_mul;
    logic                    last_step;

    function automatic logic signed [WIDTH-1:0] sext_imm5(input logic [4:0] imm);
        return $signed({{(WIDTH-5){imm[4]}}, imm});
    endfunction

    assign op_a      = $signed(SR1_OUT);
    assign op_b      = SR2MUX ? sext_imm5(IMM5) : $signed(SR2_OUT);
    assign start_mul = Start && (ALUK == 3'b100);
    assign last_step = (step_cnt == CW'(WIDTH - 1));
    assign acc_step  = acc + (mplier[0] ? mcand : '0);

    // Combinational result select; MUL reads the registered product.
    always_comb begin
        alu_res = '0;
        case (ALUK)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a & op_b;
            3'b010:  alu_res = ~op_a;
            3'b011:  alu_res = op_a;
            3'b100:  alu_res = $signed(result_q);
            default: alu_res = '0;
        endcase
    end

    assign ALU_OUT = alu_res;
    assign Busy    = (state == S_MUL);
    assign Done    = (state == S_FIN);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_mul) state_nxt = S_MUL;
            S_MUL:   if (last_step) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control and architectural state: FSM, step counter, product register, NZP.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            result_q <= '0;
            N        <= 1'b0;
            Z        <= 1'b1;
            P        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start_mul) begin
                step_cnt <= '0;
            end else if (state == S_MUL) begin
                step_cnt <= step_cnt + CW'(1);
                if (last_step) result_q <= acc_step;
            end
            if (LD_CC) begin
                N <= Bus[WIDTH-1];
                Z <= (Bus == '0);
                P <= !Bus[WIDTH-1] && (Bus != '0);
            end
        end
    end

    // Shift-add datapath: operands are captured once at Start and never re-sampled.
    always_ff @(posedge Clk) begin
        if (state == S_IDLE && start_mul) begin
            mcand  <= SR1_OUT;
            mplier <= op_b;
            acc    <= '0;
        end else if (state == S_MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: direct checks of combinational ops and NZP, plus a
// queue-based scoreboard that matches every Done pulse against a reference product.
module tb_alu_exec;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] SR1_OUT;
    logic [15:0] SR2_OUT;
    logic [4:0]  IMM5;
    logic        SR2MUX;
    logic [2:0]  ALUK;
    logic        Start;
    logic        LD_CC;
    logic [15:0] Bus;
    logic [15:0] ALU_OUT;
    logic        Busy;
    logic        Done;
    logic        N;
    logic        Z;
    logic        P;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    alu_exec #(.WIDTH(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
        .IMM5(IMM5), .SR2MUX(SR2MUX), .ALUK(ALUK), .Start(Start), .LD_CC(LD_CC),
        .Bus(Bus), .ALU_OUT(ALU_OUT), .Busy(Busy), .Done(Done), .N(N), .Z(Z), .P(P)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        return p[15:0];
    endfunction

    function automatic logic [15:0] alu_model(input logic [2:0] k, input logic [15:0] a,
                                              input logic [15:0] b2, input logic mux,
                                              input logic [4:0] imm);
        int signed bi;
        logic [15:0] b;
        bi = mux ? ((imm >= 16) ? int'(imm) - 32 : int'(imm)) : int'(b2);
        b  = bi[15:0];
        case (k)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return ~a;
            3'd3:    return a;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [2:0] nzp_model(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'h0000)  return 3'b010;
        return 3'b001;
    endfunction

    // Scoreboard monitor: every Done pulse must match the oldest outstanding product.
    always @(negedge Clk) begin
        if (Reset_n && Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("mul_result", ALU_OUT, exp_q.pop_front());
            end
        end
    end

    task automatic load_cc(input logic [15:0] v);
        Bus = v; LD_CC = 1'b1;
        @(posedge Clk); #1;
        LD_CC = 1'b0;
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input bit perturb, input bit fin_start, input bit cc_mid);
        int n;
        int guard;
        SR1_OUT = a; SR2_OUT = b; SR2MUX = 1'b0; ALUK = 3'b100; Start = 1'b1;
        exp_q.push_back(mul_model(a, b));
        @(posedge Clk); #1;
        Start = 1'b0;
        n = 0; guard = 0;
        while (!Done && guard < 40) begin
            @(negedge Clk);
            guard++;
            if (Busy) n++;
            if (perturb && n == 5) begin
                Start = 1'b1; SR1_OUT = 16'($urandom); SR2_OUT = 16'($urandom);
            end
            if (perturb && n == 6) Start = 1'b0;
            if (cc_mid && n == 3) begin Bus = 16'h8000; LD_CC = 1'b1; end
            if (cc_mid && n == 4) LD_CC = 1'b0;
        end
        check("done_seen", Done, 1'b1);
        check("busy_cycles", n, 16);
        check("busy_low_in_fin", Busy, 1'b0);
        if (cc_mid) check("cc_during_mul", {N, Z, P}, 3'b100);
        if (fin_start) Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        check("done_single", Done, 1'b0);
        if (fin_start) check("fin_start_ignored", Busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra, rb, rv;
        logic [2:0]  rk;
        logic [2:0]  held;
        int          bc;

        Reset_n = 1'b0; SR1_OUT = '0; SR2_OUT = '0; IMM5 = '0; SR2MUX = 1'b0;
        ALUK = 3'b100; Start = 1'b0; LD_CC = 1'b0; Bus = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_busy", Busy, 1'b0);
        check("reset_done", Done, 1'b0);
        check("reset_nzp", {N, Z, P}, 3'b010);
        check("reset_result", ALU_OUT, 16'h0000);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        SR1_OUT = 16'h7FFF; SR2_OUT = 16'h0001; SR2MUX = 1'b0;
        ALUK = 3'd0; #1 check("add_ovf", ALU_OUT, 16'h8000);
        ALUK = 3'd1; #1 check("and", ALU_OUT, 16'h0001);
        ALUK = 3'd2; #1 check("not", ALU_OUT, 16'h8000);
        ALUK = 3'd3; #1 check("passa", ALU_OUT, 16'h7FFF);
        SR2MUX = 1'b1; IMM5 = 5'h1F; ALUK = 3'd0;
        #1 check("add_imm_neg", ALU_OUT, 16'h7FFE);
        for (int k = 5; k < 8; k++) begin
            ALUK = 3'(k); #1 check("reserved_zero", ALU_OUT, 16'h0000);
        end
        for (int i = 0; i < 24; i++) begin
            SR1_OUT = 16'($urandom); SR2_OUT = 16'($urandom);
            IMM5 = 5'($urandom); SR2MUX = 1'($urandom);
            rk = 3'($urandom_range(0, 6));
            if (rk == 3'd4) rk = 3'd7;
            ALUK = rk;
            #1 check("rand_comb", ALU_OUT, alu_model(rk, SR1_OUT, SR2_OUT, SR2MUX, IMM5));
        end

        ALUK = 3'd0; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        @(negedge Clk);
        check("start_wrong_aluk", Busy, 1'b0);

        run_mul(16'd300, 16'd7, 1'b0, 1'b0, 1'b0);
        run_mul(16'hFFFD, 16'h0005, 1'b0, 1'b1, 1'b0);
        run_mul(16'd1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_mul(16'hBEEF, 16'h1357, 1'b1, 1'b0, 1'b0);
        run_mul(16'h8001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            run_mul(ra, rb, i[0], 1'b0, 1'b0);
        end

        load_cc(16'h8000); check("cc_neg", {N, Z, P}, 3'b100);
        load_cc(16'h0000); check("cc_zero", {N, Z, P}, 3'b010);
        load_cc(16'h0001); check("cc_pos", {N, Z, P}, 3'b001);
        for (int i = 0; i < 10; i++) begin
            rv = 16'($urandom);
            if (i == 3) rv = 16'hFFFF;
            if (i == 4) rv = 16'h7FFF;
            load_cc(rv);
            check("cc_rand", {N, Z, P}, nzp_model(rv));
        end
        held = {N, Z, P};
        for (int i = 0; i < 6; i++) begin
            Bus = 16'($urandom);
            @(posedge Clk); #1;
        end
        check("cc_hold", {N, Z, P}, held);

        run_mul(16'd25, 16'd4, 1'b0, 1'b0, 1'b1);

        run_mul(16'd300, 16'd7, 1'b0, 1'b0, 1'b0);
        SR1_OUT = 16'd99; SR2_OUT = 16'd3; ALUK = 3'b100; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (8) @(negedge Clk);
        check("busy_before_abort", Busy, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("abort_busy", Busy, 1'b0);
        check("abort_done", Done, 1'b0);
        check("abort_result", ALU_OUT, 16'h0000);
        check("abort_nzp", {N, Z, P}, 3'b010);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        bc = 0;
        repeat (25) begin
            @(negedge Clk);
            if (Busy || Done) bc++;
        end
        check("no_activity_after_abort", bc, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
